mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage.sv | 142 ++++++++++++++
 tb/tb_mem_wb_stage.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage: MEM -> WB pipeline register with valid/ready handshake.
//
// Configuration macro: MEM_WB_SKID_EN
//   undefined : single head register, in_ready = ~out_valid | out_ready.
//   defined   : head + skid entry, in_ready is registered ("skid empty").
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous squash of all held entries
//   in_valid/in_ready MEM-side handshake
//   in_regwrite, in_memtoreg, in_rd, in_mem_dout, in_alu_result  MEM beat
//   out_valid/out_ready WB-side handshake
//   out_bus           {alu_result, mem_dout, regwrite, memtoreg} of head
//   out_rd            destination register of head
//   wb_data           write-back value selected by memtoreg
//   wb_we             register-file write enable
// -----------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_W   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_regwrite,
    input  logic                  in_memtoreg,
    input  logic [RD_W-1:0]       in_rd,
    input  logic [DATA_W-1:0]     in_mem_dout,
    input  logic [DATA_W-1:0]     in_alu_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*DATA_W+1:0]   out_bus,
    output logic [RD_W-1:0]       out_rd,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  wb_we
);

    localparam int unsigned BUS_W = 2 * DATA_W + 2;
    localparam int unsigned ENT_W = BUS_W + RD_W;
    localparam int unsigned MTR_B = RD_W;
    localparam int unsigned RW_B  = RD_W + 1;
    localparam int unsigned MEM_L = RD_W + 2;
    localparam int unsigned ALU_L = RD_W + 2 + DATA_W;

    // Entry layout: {alu_result, mem_dout, regwrite, memtoreg, rd}
    logic [ENT_W-1:0] in_ent;
    logic [ENT_W-1:0] head_q, head_d;
    logic             head_valid_q, head_valid_d;
    logic             in_fire, out_fire;

    assign in_ent   = {in_alu_result, in_mem_dout, in_regwrite, in_memtoreg, in_rd};
    assign in_fire  = in_valid & in_ready;
    assign out_fire = head_valid_q & out_ready;

`ifdef MEM_WB_SKID_EN
    logic [ENT_W-1:0] skid_q, skid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             in_ready_q, in_ready_d;

    assign in_ready = in_ready_q;

    // Next state: flush wins; skid refills the head when the head drains.
    always_comb begin
        head_d       = head_q;
        head_valid_d = head_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_fire) begin
            if (skid_valid_q) begin
                head_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                head_d = in_ent;
            end else begin
                head_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            if (head_valid_q) begin
                skid_d       = in_ent;
                skid_valid_d = 1'b1;
            end else begin
                head_d       = in_ent;
                head_valid_d = 1'b1;
            end
        end
        in_ready_d = ~skid_valid_d;
    end

    // Skid register and registered ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end
`else
    assign in_ready = ~head_valid_q | out_ready;

    // Next state: flush wins and discards any same-cycle input beat.
    always_comb begin
        head_d       = head_q;
        head_valid_d = head_valid_q;
        if (flush) begin
            head_valid_d = 1'b0;
        end else if (in_fire) begin
            head_d       = in_ent;
            head_valid_d = 1'b1;
        end else if (out_fire) begin
            head_valid_d = 1'b0;
        end
    end
`endif

    // Head register; payload is left untouched when the entry empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q       <= '0;
            head_valid_q <= 1'b0;
        end else begin
            head_q       <= head_d;
            head_valid_q <= head_valid_d;
        end
    end

    assign out_valid = head_valid_q;
    assign out_bus   = head_q[ENT_W-1:RD_W];
    assign out_rd    = head_q[RD_W-1:0];
    assign wb_data   = head_q[MTR_B] ? head_q[MEM_L +: DATA_W] : head_q[ALU_L +: DATA_W];
    assign wb_we     = head_valid_q & head_q[RW_B];

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

    localparam int unsigned DW = 8;
    localparam int unsigned RW = 5;
`ifdef MEM_WB_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic            in_regwrite;
    logic            in_memtoreg;
    logic [RW-1:0]   in_rd;
    logic [DW-1:0]   in_mem_dout;
    logic [DW-1:0]   in_alu_result;
    logic            out_valid;
    logic            out_ready;
    logic [2*DW+1:0] out_bus;
    logic [RW-1:0]   out_rd;
    logic [DW-1:0]   wb_data;
    logic            wb_we;

    int n_pass  = 0;
    int n_total = 0;

    mem_wb_stage #(.DATA_W(DW), .RD_W(RW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg), .in_rd(in_rd),
        .in_mem_dout(in_mem_dout), .in_alu_result(in_alu_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bus(out_bus), .out_rd(out_rd), .wb_data(wb_data), .wb_we(wb_we)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic drive(input logic v, input logic [7:0] alu, input logic [7:0] mem,
                         input logic rw, input logic mtr, input logic [4:0] rd);
        in_valid      = v;
        in_alu_result = alu;
        in_mem_dout   = mem;
        in_regwrite   = rw;
        in_memtoreg   = mtr;
        in_rd         = rd;
    endtask

    // Reference model: a FIFO of beats {alu, mem, rw, mtr, rd} with capacity CAP.
    logic [22:0] mq[$];
    logic [22:0] shown = '0;

    task automatic rand_cycle();
        logic        exp_rdy, fire_in, fire_out, exp_we;
        logic [7:0]  s_alu, s_mem, exp_wb;
        logic [22:0] ent;
        @(negedge clk);
        drive(($urandom_range(0, 9) < 7), 8'($urandom), 8'($urandom),
              1'($urandom), 1'($urandom), 5'($urandom));
        out_ready = ($urandom_range(0, 9) < 6);
        flush     = ($urandom_range(0, 15) == 0);
        #1;
        if (CAP == 2) exp_rdy = (mq.size() < 2);
        else          exp_rdy = (mq.size() == 0) || out_ready;
        s_alu  = shown[22:15];
        s_mem  = shown[14:7];
        exp_wb = shown[5] ? s_mem : s_alu;
        exp_we = (mq.size() > 0) && shown[6];
        chk("rand_in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("rand_out_valid", 32'(out_valid), 32'(mq.size() > 0));
        chk("rand_bus_rd", 32'({out_bus, out_rd}), 32'(shown));
        chk("rand_wb", 32'({wb_data, wb_we}), 32'({exp_wb, exp_we}));
        fire_in  = in_valid && exp_rdy;
        fire_out = (mq.size() > 0) && out_ready;
        ent = {in_alu_result, in_mem_dout, in_regwrite, in_memtoreg, in_rd};
        if (flush) mq.delete();
        else begin
            if (fire_out) void'(mq.pop_front());
            if (fire_in) mq.push_back(ent);
        end
        if (mq.size() > 0) shown = mq[0];
    endtask

    typedef struct {
        logic [7:0]  alu;
        logic [7:0]  mem;
        logic        rw;
        logic        mtr;
        logic [4:0]  rd;
        logic [17:0] exp_bus;
        logic [7:0]  exp_wb;
        logic        exp_we;
    } vec_t;

    vec_t vecs[5];

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 5'd0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_bus", 32'(out_bus), 32'd0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        chk("rst_wb_data", 32'(wb_data), 32'd0);
        chk("rst_wb_we", 32'(wb_we), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Randomized traffic against the FIFO model
        for (int i = 0; i < 400; i++) rand_cycle();

        // Empty the stage before directed tests
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        flush = 1'b0;

        // Single-beat vectors: {alu, mem, rw, mtr, rd} -> {out_bus, wb_data, wb_we}
        vecs[0] = '{8'h3C, 8'hA5, 1'b1, 1'b1, 5'd7,  18'h0F297, 8'hA5, 1'b1};
        vecs[1] = '{8'h12, 8'h34, 1'b1, 1'b0, 5'd0,  18'h048D2, 8'h12, 1'b1};
        vecs[2] = '{8'hFF, 8'h00, 1'b0, 1'b1, 5'd31, 18'h3FC01, 8'h00, 1'b0};
        vecs[3] = '{8'h00, 8'hFF, 1'b0, 1'b0, 5'd1,  18'h003FC, 8'h00, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b1, 1'b1, 5'd16, 18'h20007, 8'h01, 1'b1};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            drive(1'b1, vecs[i].alu, vecs[i].mem, vecs[i].rw, vecs[i].mtr, vecs[i].rd);
            #1;
            chk("vec_in_ready", 32'(in_ready), 32'd1);
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            chk("vec_out_valid", 32'(out_valid), 32'd1);
            chk("vec_out_bus", 32'(out_bus), 32'(vecs[i].exp_bus));
            chk("vec_out_rd", 32'(out_rd), 32'(vecs[i].rd));
            chk("vec_wb_data", 32'(wb_data), 32'(vecs[i].exp_wb));
            chk("vec_wb_we", 32'(wb_we), 32'(vecs[i].exp_we));
            @(negedge clk);
            #1;
            chk("vec_drained_valid", 32'(out_valid), 32'd0);
            chk("vec_drained_we", 32'(wb_we), 32'd0);
            chk("vec_hold_bus", 32'(out_bus), 32'(vecs[i].exp_bus));
        end

        // Streaming: 8 back-to-back beats, one output per cycle
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (k < 8) drive(1'b1, 8'(8'h40 + k), 8'(k), 1'b1, 1'b0, 5'(k));
            else       in_valid = 1'b0;
            #1;
            if (k < 8) chk("stream_in_ready", 32'(in_ready), 32'd1);
            if (k > 0) begin
                chk("stream_out_valid", 32'(out_valid), 32'd1);
                chk("stream_wb_data", 32'(wb_data), 32'(8'h40 + k - 1));
                chk("stream_out_rd", 32'(out_rd), 32'(k - 1));
            end
        end
        @(negedge clk);
        #1;
        chk("stream_end_valid", 32'(out_valid), 32'd0);

`ifdef MEM_WB_SKID_EN
        // Stall with two beats offered: both held, head stays first
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 8'h11, 8'h00, 1'b1, 1'b0, 5'd1);
        @(negedge clk);
        drive(1'b1, 8'h22, 8'h00, 1'b1, 1'b0, 5'd2);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("skid_in_ready_full", 32'(in_ready), 32'd0);
        chk("skid_head_stall", 32'(wb_data), 32'h11);
        @(negedge clk);
        #1;
        chk("skid_head_stall2", 32'(wb_data), 32'h11);
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("skid_second_valid", 32'(out_valid), 32'd1);
        chk("skid_second_data", 32'(wb_data), 32'h22);
        @(negedge clk);
        #1;
        chk("skid_drained", 32'(out_valid), 32'd0);
`else
        // Combinational ready follows out_ready while head is valid
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 8'h77, 8'h00, 1'b1, 1'b0, 5'd3);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("comb_stall_valid", 32'(out_valid), 32'd1);
        chk("comb_in_ready_lo", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("comb_in_ready_hi", 32'(in_ready), 32'd1);
        @(negedge clk);
        #1;
        chk("comb_drained", 32'(out_valid), 32'd0);
`endif

        // Flush with beats held and a new beat offered in the same cycle
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 8'hA1, 8'h00, 1'b1, 1'b0, 5'd4);
        @(negedge clk);
        drive(1'b1, 8'hA2, 8'h00, 1'b1, 1'b0, 5'd5);
        #1;
        chk("flush_pre_head", 32'(wb_data), 32'hA1);
        @(negedge clk);
        flush = 1'b1;
        drive(1'b1, 8'hA3, 8'h00, 1'b1, 1'b0, 5'd6);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("flush_no_beat", 32'(out_valid), 32'd0);
        end

        // Asynchronous reset pulse mid-stall
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 8'h5A, 8'h66, 1'b1, 1'b1, 5'd9);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("arst_pre_valid", 32'(out_valid), 32'd1);
        chk("arst_pre_we", 32'(wb_we), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_bus", 32'(out_bus), 32'd0);
        chk("arst_out_rd", 32'(out_rd), 32'd0);
        chk("arst_wb_data", 32'(wb_data), 32'd0);
        chk("arst_wb_we", 32'(wb_we), 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("arst_no_stale", 32'(out_valid), 32'd0);
        end
        chk("arst_in_ready", 32'(in_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
